// File: rtl/stack_mem_ctrl_pkg.sv
// Shared constants for the stack PUSH/POP memory engine: FSM encoding,
// error codes and default stack bounds.
package stack_mem_ctrl_pkg;

    localparam int unsigned SMC_DATA_W = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    localparam logic [1:0] ERR_OVERFLOW  = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

    localparam logic [SMC_DATA_W-1:0] DEF_STACK_TOP   = 16'h0400;
    localparam logic [SMC_DATA_W-1:0] DEF_STACK_LIMIT = 16'h0300;
    localparam int unsigned           DEF_TIMEOUT     = 15;

endpackage

// File: rtl/stack_wait_timer.sv
// Wait-cycle counter for memory handshakes: clear on access start, count
// non-ready cycles, flag the cycle that reaches the timeout.
module stack_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Fires during the TIMEOUT-th consecutive non-ready cycle.
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/stack_mem_ctrl.sv
// Stack PUSH/POP memory engine: bounds-checks SP, runs one data-memory access
// with a ready handshake, then strobes the register file to move SP.
module stack_mem_ctrl
    import stack_mem_ctrl_pkg::*;
#(
    parameter int unsigned        DATA_W      = SMC_DATA_W,
    parameter logic [DATA_W-1:0]  STACK_TOP   = DEF_STACK_TOP,
    parameter logic [DATA_W-1:0]  STACK_LIMIT = DEF_STACK_LIMIT,
    parameter int unsigned        TIMEOUT     = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic [DATA_W-1:0] push_data,
    input  logic [DATA_W-1:0] sp_in,
    output logic              req_ready,
    output logic              sp_push,
    output logic              sp_pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              is_push_q, is_push_d;
    logic              tmr_clr, tmr_en, tmr_expired;

    stack_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

    assign tmr_en = ((state_q == ST_WRITE) || (state_q == ST_READ)) && !mem_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pop_data_d = pop_data_q;
        err_code_d = err_code_q;
        is_push_d  = is_push_q;
        tmr_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (push_req && pop_req) begin
                    err_code_d = ERR_ILLEGAL;
                    state_d    = ST_FAIL;
                end else if (push_req) begin
                    if (sp_in == STACK_LIMIT) begin
                        err_code_d = ERR_OVERFLOW;
                        state_d    = ST_FAIL;
                    end else begin
                        // SP points at the last filled slot; push goes one below.
                        addr_d    = sp_in - DATA_W'(1);
                        wdata_d   = push_data;
                        is_push_d = 1'b1;
                        tmr_clr   = 1'b1;
                        state_d   = ST_WRITE;
                    end
                end else if (pop_req) begin
                    if (sp_in == STACK_TOP) begin
                        err_code_d = ERR_UNDERFLOW;
                        state_d    = ST_FAIL;
                    end else begin
                        addr_d    = sp_in;
                        is_push_d = 1'b0;
                        tmr_clr   = 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    state_d = ST_COMMIT;
                end else if (tmr_expired) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_FAIL;
                end
            end
            ST_READ: begin
                if (mem_ready) begin
                    pop_data_d = mem_rdata;
                    state_d    = ST_COMMIT;
                end else if (tmr_expired) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_FAIL;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            ST_FAIL:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            pop_data_q <= '0;
            err_code_q <= ERR_OVERFLOW;
            is_push_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            pop_data_q <= pop_data_d;
            err_code_q <= err_code_d;
            is_push_q  <= is_push_d;
        end
    end

    // Outputs decode straight from state so reset drops the access immediately.
    assign req_ready = (state_q == ST_IDLE);
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_re    = (state_q == ST_READ);
    assign done      = (state_q == ST_COMMIT);
    assign sp_push   = (state_q == ST_COMMIT) && is_push_q;
    assign sp_pop    = (state_q == ST_COMMIT) && !is_push_q;
    assign err       = (state_q == ST_FAIL);
    assign err_code  = err_code_q;
    assign pop_data  = pop_data_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed bench for stack_mem_ctrl: push/pop, bounds errors, illegal request,
// timeout and asynchronous reset mid-access.
module tb_stack_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        push_req, pop_req;
    logic [15:0] push_data, sp_in;
    logic        req_ready, sp_push, sp_pop, done, err;
    logic [15:0] pop_data, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  err_code;
    logic        mem_we, mem_re, mem_ready;

    int tests = 0;
    int fails = 0;
    int cnt;

    always #5 clk = ~clk;

    stack_mem_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .push_req (push_req),
        .pop_req  (pop_req),
        .push_data(push_data),
        .sp_in    (sp_in),
        .req_ready(req_ready),
        .sp_push  (sp_push),
        .sp_pop   (sp_pop),
        .pop_data (pop_data),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; push_req = 0; pop_req = 0; push_data = '0; sp_in = 16'h0400;
        mem_rdata = '0; mem_ready = 0;
        #12;
        chk("rst req_ready", req_ready, 1);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst err_code", err_code, 0);
        chk("rst pop_data", pop_data, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_re", mem_re, 0);
        reset = 1'b1;
        tick();

        // push BEEF, zero-wait memory
        push_req = 1; push_data = 16'hBEEF; sp_in = 16'h0400; mem_ready = 1;
        chk("push req_ready", req_ready, 1);
        tick();
        push_req = 0;
        chk("push mem_we", mem_we, 1);
        chk("push addr", mem_addr, 16'h03FF);
        chk("push wdata", mem_wdata, 16'hBEEF);
        chk("push early done", done, 0);
        tick();
        mem_ready = 0;
        chk("push sp_push", sp_push, 1);
        chk("push sp_pop", sp_pop, 0);
        chk("push done", done, 1);
        chk("push we off", mem_we, 0);
        tick();
        chk("push idle ready", req_ready, 1);
        chk("push strobe end", sp_push, 0);
        chk("push done end", done, 0);

        // pop with 3 wait cycles
        pop_req = 1; sp_in = 16'h03FF; mem_rdata = 16'hBEEF;
        tick();
        pop_req = 0;
        chk("pop addr", mem_addr, 16'h03FF);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_re) cnt++;
            tick();
        end
        mem_ready = 1;
        if (mem_re) cnt++;
        chk("pop re cycles", cnt, 4);
        tick();
        mem_ready = 0;
        chk("pop sp_pop", sp_pop, 1);
        chk("pop sp_push", sp_push, 0);
        chk("pop done", done, 1);
        chk("pop data", pop_data, 16'hBEEF);
        chk("pop re off", mem_re, 0);
        tick();
        chk("pop strobe end", sp_pop, 0);

        // underflow
        pop_req = 1; sp_in = 16'h0400;
        tick();
        pop_req = 0;
        chk("unf err", err, 1);
        chk("unf code", err_code, 1);
        chk("unf mem_re", mem_re, 0);
        chk("unf sp_pop", sp_pop, 0);
        tick();
        chk("unf err end", err, 0);
        chk("unf code held", err_code, 1);

        // overflow
        push_req = 1; sp_in = 16'h0300;
        tick();
        push_req = 0;
        chk("ovf err", err, 1);
        chk("ovf code", err_code, 0);
        chk("ovf mem_we", mem_we, 0);
        chk("ovf sp_push", sp_push, 0);
        tick();

        // illegal: both requests
        push_req = 1; pop_req = 1; sp_in = 16'h03F0;
        tick();
        push_req = 0; pop_req = 0;
        chk("ill err", err, 1);
        chk("ill code", err_code, 2);
        chk("ill mem_we", mem_we, 0);
        chk("ill mem_re", mem_re, 0);
        tick();
        chk("ill ready", req_ready, 1);

        // timeout on write
        push_req = 1; sp_in = 16'h0400; push_data = 16'h1234;
        tick();
        push_req = 0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (mem_we) cnt++;
            tick();
        end
        chk("tmo we cycles", cnt, 15);
        chk("tmo err", err, 1);
        chk("tmo code", err_code, 3);
        chk("tmo sp_push", sp_push, 0);
        chk("tmo we off", mem_we, 0);
        tick();

        // next push completes normally
        push_req = 1; sp_in = 16'h03FF; push_data = 16'h5555; mem_ready = 1;
        tick();
        push_req = 0;
        chk("post push addr", mem_addr, 16'h03FE);
        chk("post push wdata", mem_wdata, 16'h5555);
        tick();
        mem_ready = 0;
        chk("post push done", done, 1);
        chk("post push sp_push", sp_push, 1);
        tick();

        // reset during READ wait
        pop_req = 1; sp_in = 16'h03FE;
        tick();
        pop_req = 0;
        chk("rstmid re", mem_re, 1);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("rstmid re drop", mem_re, 0);
        chk("rstmid sp_pop", sp_pop, 0);
        chk("rstmid pop_data", pop_data, 0);
        chk("rstmid ready", req_ready, 1);
        #2 reset = 1'b1;
        tick();
        chk("rstrel ready", req_ready, 1);
        chk("rstrel sp_pop", sp_pop, 0);
        chk("rstrel done", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
